// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request, memory and response signals of the memory access unit
//
// Purpose: groups the AG-side request handshake, the word-organised memory
// port and the completion response into one bundle.
// Modports:
//   master - the access unit itself (drives in_ready, mem_*, resp_*)
//   slave  - the environment: AG stage plus data memory (drives in_*, mem_ack, mem_rdata)
interface mem_access_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [1:0]  in_size;
  logic        in_we;
  logic [31:0] in_wdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    input  in_valid, in_addr, in_size, in_we, in_wdata, mem_ack, mem_rdata,
    output in_ready, mem_req, mem_addr, mem_we, mem_be, mem_wdata, resp_valid, resp_data
  );

  modport slave (
    output in_valid, in_addr, in_size, in_we, in_wdata, mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_addr, mem_we, mem_be, mem_wdata, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer splitting unaligned accesses into word transactions
//
// Purpose: accepts one byte-addressed load/store at a time and performs it as
// one or two 32-bit word transactions, merging split load data into a
// right-justified, zero-extended result.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - mem_access_unit_if.master: in_* request handshake, mem_* word
//         port, resp_valid/resp_data one-cycle completion
module mem_access_unit (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_unit_if.master    bus
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] nb);
    case (nb)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  state_t      state_q;
  logic        in_ready_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;

  logic [29:0] word_q;    // word index of the first transaction
  logic [1:0]  off_q;
  logic [2:0]  nb_q;
  logic        split_q;
  logic        we_q;
  logic [3:0]  be2_q;     // second-transaction lanes, precomputed at accept
  logic [31:0] wd2_q;
  logic [31:0] merged_q;

  // Request-side decode. Shifting into a double-width vector yields both
  // transactions at once: the low half is word 1, the spill-over is word 2.
  logic [1:0]  in_off;
  logic [2:0]  in_nb;
  logic [7:0]  in_be_wide;
  logic [63:0] in_wd_wide;
  logic        in_split;

  // Load merge path
  logic [31:0] data_mask;
  logic [31:0] part1_d;
  logic [31:0] part2_d;
  logic [31:0] merged2_d;

  always_comb begin
    in_off     = bus.in_addr[1:0];
    in_nb      = size_bytes(bus.in_size);
    in_be_wide = {4'b0000, lane_mask(in_nb)} << in_off;
    in_wd_wide = {32'd0, bus.in_wdata} << {in_off, 3'b000};
    in_split   = ({1'b0, in_nb} + {2'b00, in_off}) > 4'd4;

    case (nb_q)
      3'd1:    data_mask = 32'h0000_00FF;
      3'd2:    data_mask = 32'h0000_FFFF;
      default: data_mask = 32'hFFFF_FFFF;
    endcase
    part1_d   = bus.mem_rdata >> {off_q, 3'b000};
    // off_q is never 0 on a split, so the shift is 8..24
    part2_d   = bus.mem_rdata << (6'd32 - {1'b0, off_q, 3'b000});
    merged2_d = merged_q | part2_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      word_q       <= 30'd0;
      off_q        <= 2'd0;
      nb_q         <= 3'd0;
      split_q      <= 1'b0;
      we_q         <= 1'b0;
      be2_q        <= 4'd0;
      wd2_q        <= 32'd0;
      merged_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            word_q      <= bus.in_addr[31:2];
            off_q       <= in_off;
            nb_q        <= in_nb;
            split_q     <= in_split;
            we_q        <= bus.in_we;
            be2_q       <= in_be_wide[7:4];
            wd2_q       <= in_wd_wide[63:32];
            merged_q    <= 32'd0;
            in_ready_q  <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= {bus.in_addr[31:2], 2'b00};
            mem_we_q    <= bus.in_we;
            mem_be_q    <= in_be_wide[3:0];
            mem_wdata_q <= in_wd_wide[31:0];
            state_q     <= ACC1;
          end
        end
        ACC1: begin
          if (bus.mem_ack) begin
            merged_q <= we_q ? 32'd0 : part1_d;
            if (split_q) begin
              mem_addr_q  <= {word_q + 30'd1, 2'b00};  // wraps modulo 2^30 words
              mem_be_q    <= be2_q;
              mem_wdata_q <= wd2_q;
              state_q     <= ACC2;
            end else begin
              mem_req_q    <= 1'b0;
              mem_be_q     <= 4'd0;
              mem_wdata_q  <= 32'd0;
              resp_valid_q <= 1'b1;
              resp_data_q  <= we_q ? 32'd0 : (part1_d & data_mask);
              state_q      <= RESP;
            end
          end
        end
        ACC2: begin
          if (bus.mem_ack) begin
            merged_q     <= we_q ? 32'd0 : merged2_d;
            mem_req_q    <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= we_q ? 32'd0 : (merged2_d & data_mask);
            state_q      <= RESP;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          resp_data_q  <= 32'd0;
          in_ready_q   <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access sequencer that consumes the linear address produced by the address-generation stage and performs the actual load or store against a 32-bit word-organised data memory. It accepts one request at a time over a valid/ready handshake. Any access that crosses a 4-byte word boundary is split into two word transactions, and load bytes from both halves are merged into a single right-justified, zero-extended result. It sits between the AG stage and the data-cache/memory port.

## Interface
Parameters:
- none; datapath width is fixed at 32 bits, word size is 4 bytes.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present from AG stage
- in_ready  out  1  unit can accept a request
- in_addr  in  32  linear byte address from AG
- in_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = treated as 4 bytes
- in_we  in  1  1 = store, 0 = load
- in_wdata  in  32  store data, right-justified
- mem_req  out  1  memory transaction request
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_we  out  1  transaction is a write
- mem_be  out  4  byte enables, bit i selects byte i of the word
- mem_wdata  out  32  write data, lane-aligned
- mem_ack  in  1  memory completed the current transaction
- mem_rdata  in  32  read word, valid when mem_ack = 1
- resp_valid  out  1  one-cycle completion pulse, for loads and stores
- resp_data  out  32  load result, zero-extended; 0 for stores

## Operation
- Let o = in_addr[1:0] and n = bytes(in_size). The access splits when o + n > 4.
- States: IDLE, ACC1, ACC2, RESP.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch addr, size, we and wdata, then go to ACC1.
- ACC1:
  - mem_addr = {addr[31:2], 2'b00}.
  - mem_be = mask(n) << o, truncated to 4 bits.
  - mem_wdata = wdata << 8*o.
  - On mem_ack: go to ACC2 if split, otherwise RESP. For loads, latch part1 = mem_rdata >> 8*o.
- ACC2:
  - mem_addr = {addr[31:2] + 1, 2'b00}. The word index wraps modulo 2^30, so 0xFFFFFFFC is followed by 0x00000000.
  - mem_be = mask(o + n − 4).
  - mem_wdata = wdata >> 8*(4 − o).
  - On mem_ack: for loads, OR in mem_rdata << 8*(4 − o), then go to RESP.
- RESP:
  - resp_valid = 1.
  - resp_data = merged value masked to n bytes, upper bytes zero.
  - Always returns to IDLE the next cycle; the unit applies no backpressure on the response.
- mem_req = 1 in ACC1 and ACC2, 0 otherwise. mem_we = latched we.
- All mem_* outputs are registered or decoded from registered state only. They hold stable while mem_req = 1 and mem_ack = 0.
- mem_ack is ignored outside ACC1 and ACC2.
- rst asserted in any state:
  - Immediately forces IDLE.
  - Drives mem_req = 0, resp_valid = 0, and all data/address outputs to 0.
  - Discards any in-flight transaction.

## Timing
- Reset values: in_ready = 1, mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, resp_valid = 0, resp_data = 0.
- Handshake: a request is accepted on an edge where in_valid & in_ready. mem_req rises in the following cycle.
- Zero-wait memory (mem_ack high in the first req cycle):
  - Non-split access: resp_valid pulses 2 cycles after acceptance.
  - Split access: resp_valid pulses 3 cycles after acceptance.
- Each wait cycle on mem_ack adds one cycle of latency per transaction.
- Throughput: at most one request in flight. in_ready stays low from acceptance until the cycle after resp_valid.
- A new request may be accepted in the cycle immediately after RESP.

## Test plan
- Aligned 4-byte load at 0x00001000, zero-wait memory, mem_rdata = 0xDEADBEEF:
  - Expect one transaction, mem_be = 4'b1111.
  - Expect resp_data = 0xDEADBEEF, resp_valid 2 cycles after acceptance.
- Split 4-byte load at 0x00001003:
  - Transaction 1: mem_addr = 0x1000, be = 4'b1000, rdata = 0xAABBCCDD.
  - Transaction 2: mem_addr = 0x1004, be = 4'b0111, rdata = 0x11223344.
  - Expect resp_data = 0x223344AA.
- Split 2-byte store at 0x00002003, in_wdata = 0x0000BEEF:
  - Transaction 1: be = 4'b1000, wdata = 0xEF000000.
  - Transaction 2: addr = 0x2004, be = 4'b0001, wdata = 0x000000BE.
  - Expect resp_valid with resp_data = 0.
- 1-byte load at 0x00003002, rdata = 0x12345678, mem_ack delayed 3 cycles:
  - Expect mem_req and mem_addr held stable throughout the wait.
  - Expect resp_data = 0x00000034.
- 4-byte load at 0xFFFFFFFE:
  - Expect transaction 1 at 0xFFFFFFFC with be = 4'b1100.
  - Expect transaction 2 at 0x00000000 with be = 4'b0011.
- Assert rst during ACC2 of a split load:
  - Expect mem_req to drop immediately, no resp_valid, and in_ready = 1 after reset.
  - A subsequent aligned load completes normally.
